// File: rtl/rbcla_serial_sub_20_pkg.sv
// Shared definitions for the serial ripple-block look-ahead subtractor.
package rbcla_pkg;

    localparam int WIDTH = 20;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;
    localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rbcla_serial_sub_20_chk.sv
// Consistency checker for the serial subtractor: the slice's block G/P must
// agree with its ripple carry-out, and the FSM must stay in a legal state.
module rbcla_serial_sub_20_chk
    import rbcla_pkg::*;
(
    input logic   clk,
    input logic   rst,
    input state_t state,
    input logic   cin,
    input logic   cout,
    input logic   g_blk,
    input logic   p_blk
);

    // Sample the invariants once per cycle outside reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cout == (g_blk | (p_blk & cin)))
                else $error("cla slice carry-out disagrees with block G/P");
            assert ((state == IDLE) || (state == RUN) || (state == DONE))
                else $error("illegal FSM state");
        end
    end

endmodule

// File: rtl/rbcla_serial_sub_20_cla_blk_4.sv
// 4-bit carry look-ahead slice: generate/propagate per bit, carries expanded
// in two-level form, plus block-level G/P for hierarchical look-ahead.
module cla_blk_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       g_blk,
    output logic       p_blk
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    // Bit generate/propagate, look-ahead carries and sum bits.
    always_comb begin
        g_s    = a & b;
        p_s    = a ^ b;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        s      = p_s ^ c_s[3:0];
        cout   = c_s[4];
        g_blk  = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
        p_blk  = &p_s;
    end

endmodule

// File: rtl/rbcla_serial_sub_20.sv
// Serial 20-bit subtractor: D = X + ~Y + 1, one 4-bit look-ahead block per
// cycle with the inter-block carry held in a register. valid/ready on both
// sides; no overlap between consecutive operations.
module rbcla_serial_sub_20 #(
    parameter int WIDTH = rbcla_pkg::WIDTH,
    parameter int BLK   = rbcla_pkg::BLK    // slice is fixed at 4 bits
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   d
);

    import rbcla_pkg::*;

    localparam int NB = WIDTH / BLK;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    state_t           state_r;
    state_t           state_next_s;
    logic [KW-1:0]    k_r;
    logic             carry_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH:0]   d_r;

    logic [WIDTH-1:0] x_shift_s;
    logic [WIDTH-1:0] y_shift_s;
    logic [BLK-1:0]   a_blk_s;
    logic [BLK-1:0]   b_blk_s;
    logic [BLK-1:0]   sum_s;
    logic             cout_s;
    logic             g_blk_s;
    logic             p_blk_s;
    logic             last_s;

    // Block select: shifting by k*BLK is the k-way mux onto the slice inputs.
    assign x_shift_s = x_r >> (k_r * BLK);
    assign y_shift_s = y_r >> (k_r * BLK);
    assign a_blk_s   = x_shift_s[BLK-1:0];
    assign b_blk_s   = ~y_shift_s[BLK-1:0];
    assign last_s    = (k_r == KW'(NB - 1));

    cla_blk_4 u_cla (
        .a     (a_blk_s),
        .b     (b_blk_s),
        .cin   (carry_r),
        .s     (sum_s),
        .cout  (cout_s),
        .g_blk (g_blk_s),
        .p_blk (p_blk_s)
    );

    rbcla_serial_sub_20_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .state (state_r),
        .cin   (carry_r),
        .cout  (cout_s),
        .g_blk (g_blk_s),
        .p_blk (p_blk_s)
    );

    // Next-state decode for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = RUN;
                else          state_next_s = IDLE;
            end
            RUN: begin
                if (last_s) state_next_s = DONE;
                else        state_next_s = RUN;
            end
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Datapath: operand capture, per-block sum write-back and carry ripple.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r     <= {WIDTH{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            d_r     <= {(WIDTH + 1){1'b0}};
            carry_r <= 1'b1;
            k_r     <= {KW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r     <= x;
                        y_r     <= y;
                        d_r     <= {(WIDTH + 1){1'b0}};
                        carry_r <= 1'b1;
                        k_r     <= {KW{1'b0}};
                    end
                end
                RUN: begin
                    for (int i = 0; i < NB; i++) begin
                        if (k_r == KW'(i)) d_r[i*BLK +: BLK] <= sum_s;
                    end
                    carry_r <= cout_s;
                    if (last_s) begin
                        d_r[WIDTH] <= ~cout_s;
                        k_r        <= {KW{1'b0}};
                    end else begin
                        k_r        <= k_r + KW'(1);
                    end
                end
                DONE: begin
                    d_r <= d_r;
                end
                default: begin
                    d_r <= {(WIDTH + 1){1'b0}};
                end
            endcase
        end
    end

    // Handshake flags are decoded straight from the state register.
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign d         = d_r;

endmodule

// File: tb/tb_rbcla_serial_sub_20.sv
// Self-checking bench for rbcla_serial_sub_20: directed corner cases plus
// random operands with random backpressure against an integer model.
module tb_rbcla_serial_sub_20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] x;
    logic [19:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] d;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int prev_accept;
    int prev_hold;
    bit have_prev;

    rbcla_serial_sub_20 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: integer difference reduced modulo 2^21.
    function automatic logic [31:0] model(input logic [19:0] xv, input logic [19:0] yv);
        longint diff;
        diff = longint'(xv) - longint'(yv);
        if (diff < 0) diff = diff + 64'sd2097152;
        return 32'(diff);
    endfunction

    task automatic do_op(input logic [19:0] xv, input logic [19:0] yv, input int hold);
        int cnt;
        logic [31:0] exp_d;
        exp_d = model(xv, yv);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x = xv;
        y = yv;
        @(negedge clk);
        if (have_prev) check("accept_period", 32'(cyc - prev_accept), 32'(7 + prev_hold));
        prev_accept = cyc;
        prev_hold   = hold;
        have_prev   = 1'b1;
        in_valid = 1'b0;
        x = 20'($urandom);
        y = 20'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            check("in_ready_run", {31'd0, in_ready}, 32'd0);
            in_valid = 1'($urandom);
            x = 20'($urandom);
            y = 20'($urandom);
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        check("latency", 32'(cnt), 32'd5);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        check("d_value", {11'd0, d}, exp_d);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x = 20'($urandom);
            y = 20'($urandom);
            @(negedge clk);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_d", {11'd0, d}, exp_d);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 20'd0;
        y         = 20'd0;
        have_prev = 1'b0;
        prev_accept = 0;
        prev_hold   = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_d", {11'd0, d}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(20'h00005, 20'h00003, 0);
        check("vec_5_3", {11'd0, d}, 32'h000002);
        do_op(20'hFFFFF, 20'hFFFFF, 0);
        check("vec_eq", {11'd0, d}, 32'h000000);
        do_op(20'h00000, 20'h00001, 1);
        check("vec_m1", {11'd0, d}, 32'h1FFFFF);
        do_op(20'h00000, 20'hFFFFF, 0);
        check("vec_borrow", {11'd0, d}, 32'h100001);
        do_op(20'h10000, 20'h0FFFF, 0);
        check("vec_ripple", {11'd0, d}, 32'h000001);
        do_op(20'hABCDE, 20'h12345, 3);

        // Reset in the middle of RUN, after three blocks have been written.
        in_valid = 1'b1;
        x = 20'hFFFFF;
        y = 20'h00001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_d", {11'd0, d}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        have_prev = 1'b0;
        @(negedge clk);
        do_op(20'h12345, 20'h02345, 0);
        check("vec_after_rst", {11'd0, d}, 32'h010000);

        for (int n = 0; n < 40; n++) begin
            do_op(20'($urandom), 20'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
